// File: rtl/intersection_model.sv
// -----------------------------------------------------------------------------
// intersection_model
//
// Behavioural model of the intersection driven by the traffic-light
// controller. It keeps one vehicle queue per street and reports traffic
// presence (Ta/Tb) back to the controller. It also watches the light stream
// for protocol violations.
//
// Optional build macro: STARVE_DETECT_EN
//   defined   -> per-street starvation counters drive starve_a/starve_b
//   undefined -> counters are absent and starve_a/starve_b are tied to 0
//
// Ports
//   clk                 clock
//   reset               asynchronous, active-high reset
//   arrive_a/arrive_b   one car arrives on street A/B this cycle
//   La/Lb               light codes: 00 GREEN, 01 YELLOW, 10 RED, 11 illegal
//   clr_err             synchronous clear of all sticky flags (a set wins)
//   Ta/Tb               street has queued traffic (from registered counts)
//   qa_count/qb_count   queue occupancy, saturating at 2^QW-1
//   depart_a/depart_b   one-cycle pulse, a car left the street
//   ovf_a/ovf_b         sticky, arrival dropped at a full queue
//   conflict            sticky, La and Lb both non-RED in the same cycle
//   illegal             sticky, code 11 seen on La or Lb
//   seq_err             sticky, illegal colour transition on either light
//   starve_a/starve_b   sticky starvation flags
// -----------------------------------------------------------------------------
module intersection_model #(
  parameter int QW           = 4,
  parameter int DEPART_TICKS = 3,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arrive_a,
  input  logic          arrive_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  input  logic          clr_err,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] qa_count,
  output logic [QW-1:0] qb_count,
  output logic          depart_a,
  output logic          depart_b,
  output logic          ovf_a,
  output logic          ovf_b,
  output logic          conflict,
  output logic          illegal,
  output logic          seq_err,
  output logic          starve_a,
  output logic          starve_b
);

  localparam logic [1:0] COL_GREEN  = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_RED    = 2'b10;
  localparam logic [1:0] COL_ILL    = 2'b11;

  localparam int            TW       = (DEPART_TICKS > 1) ? $clog2(DEPART_TICKS) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(DEPART_TICKS - 1);
  localparam logic [QW-1:0] Q_MAX    = {QW{1'b1}};

  // Elaboration-time guard on parameters that have a lower bound.
  if (DEPART_TICKS < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("intersection_model: DEPART_TICKS and STARVE_LIMIT must be >= 1");
  end

  // Index 0 is street A, index 1 is street B.
  logic [1:0][1:0]    light_w;
  logic [1:0]         arrive_w;
  logic [1:0][QW-1:0] count_w;
  logic [1:0]         depart_w;
  logic [1:0]         ovf_set_w;
  logic [1:0]         seq_set_w;
  logic [1:0]         ill_set_w;
  logic [1:0]         starve_w;

  assign light_w  = {Lb, La};
  assign arrive_w = {arrive_b, arrive_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_street
    logic [QW-1:0] count_q, count_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    prev_q;
    logic          prev_ill_q;
    logic          depart_q;
    logic          green, busy, leave, cur_ill;
    logic          ovf_set, seq_set, ill_set;

    assign green   = (light_w[gi] == COL_GREEN);
    assign busy    = (count_q != '0);
    assign cur_ill = (light_w[gi] == COL_ILL);
    // A car leaves on the last tick of a contiguous GREEN run with a
    // non-empty queue, so a departure can never happen at count 0.
    assign leave   = green && busy && (tmr_q == TMR_LAST);

    always_comb begin
      tmr_d = '0;
      if (green && busy && !leave) begin
        tmr_d = tmr_q + 1'b1;
      end

      count_d = count_q;
      ovf_set = 1'b0;
      if (arrive_w[gi] && !leave) begin
        if (count_q == Q_MAX) begin
          ovf_set = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (!arrive_w[gi] && leave) begin
        count_d = count_q - 1'b1;
      end
      // Arrival together with departure leaves the count unchanged.

      // Any transition touching code 11 is reported as illegal only, so the
      // colour-order check is masked in that case.
      ill_set = cur_ill || prev_ill_q;
      seq_set = 1'b0;
      if (!ill_set) begin
        if ((prev_q == COL_GREEN  && light_w[gi] == COL_RED)    ||
            (prev_q == COL_YELLOW && light_w[gi] == COL_GREEN)  ||
            (prev_q == COL_RED    && light_w[gi] == COL_YELLOW)) begin
          seq_set = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_q    <= '0;
        tmr_q      <= '0;
        prev_q     <= COL_RED;
        prev_ill_q <= 1'b0;
        depart_q   <= 1'b0;
      end else begin
        count_q    <= count_d;
        tmr_q      <= tmr_d;
        // An illegal code is remembered as RED for the next order check.
        prev_q     <= cur_ill ? COL_RED : light_w[gi];
        prev_ill_q <= cur_ill;
        depart_q   <= leave;
      end
    end

    assign count_w[gi]   = count_q;
    assign depart_w[gi]  = depart_q;
    assign ovf_set_w[gi] = ovf_set;
    assign seq_set_w[gi] = seq_set;
    assign ill_set_w[gi] = ill_set;

`ifdef STARVE_DETECT_EN
    localparam int            SW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] S_LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] scnt_q, scnt_d;
    logic          starve_set;
    logic          starve_q;

    always_comb begin
      scnt_d     = '0;
      starve_set = 1'b0;
      if (!green && busy) begin
        scnt_d     = (scnt_q == S_LIMIT) ? scnt_q : scnt_q + 1'b1;
        // Flag rises on the same edge the counter reaches the limit.
        starve_set = (scnt_q >= S_LIMIT - 1'b1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        scnt_q   <= '0;
        starve_q <= 1'b0;
      end else begin
        scnt_q   <= scnt_d;
        starve_q <= (starve_q & ~clr_err) | starve_set;
      end
    end

    assign starve_w[gi] = starve_q;
`else
    assign starve_w[gi] = 1'b0;
`endif
  end

  // Shared sticky flags: a set condition in the clr_err cycle wins.
  logic [1:0] ovf_q;
  logic       conflict_q;
  logic       illegal_q;
  logic       seq_err_q;
  logic       conflict_now;

  assign conflict_now = (La != COL_RED) && (Lb != COL_RED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q      <= '0;
      conflict_q <= 1'b0;
      illegal_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      ovf_q      <= (ovf_q & {2{~clr_err}}) | ovf_set_w;
      conflict_q <= (conflict_q & ~clr_err) | conflict_now;
      illegal_q  <= (illegal_q  & ~clr_err) | (|ill_set_w);
      seq_err_q  <= (seq_err_q  & ~clr_err) | (|seq_set_w);
    end
  end

  assign qa_count = count_w[0];
  assign qb_count = count_w[1];
  assign Ta       = (count_w[0] != '0);
  assign Tb       = (count_w[1] != '0);
  assign depart_a = depart_w[0];
  assign depart_b = depart_w[1];
  assign ovf_a    = ovf_q[0];
  assign ovf_b    = ovf_q[1];
  assign conflict = conflict_q;
  assign illegal  = illegal_q;
  assign seq_err  = seq_err_q;
  assign starve_a = starve_w[0];
  assign starve_b = starve_w[1];

endmodule
